// File: rtl/board_rev1_reset_seq.sv
// Reset sequencer for the board clock block's lock/ready interface.
// Synchronizes and filters the memory-PLL and TMDS-PLL ready levels, then
// releases memory, system (after a memory-init wait) and TMDS resets.
module board_rev1_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MEM_INIT_CYCLES    = 21600,
    parameter int LOSS_FILTER        = 4
) (
    input  logic       CLK_BASE,
    input  logic       RESET_n,
    input  logic       MEM_READY_IN,
    input  logic       TMDS_READY_IN,
    output logic       MEM_RESET_n,
    output logic       SYS_RESET_n,
    output logic       TMDS_RESET_n,
    output logic [1:0] STATE,
    output logic [7:0] LOSS_COUNT
);

    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int IW = $clog2(MEM_INIT_CYCLES + 1);
    localparam int LW = $clog2(LOSS_FILTER + 1);

    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SW-1:0] TMDS_LAST   = SW'(LOCK_STABLE_CYCLES);
    localparam logic [IW-1:0] INIT_LAST   = IW'(MEM_INIT_CYCLES - 1);
    localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_FILTER - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STABLE   = 2'd1,
        ST_MEM_INIT = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    typedef enum logic {
        T_HOLD = 1'b0,
        T_GO   = 1'b1
    } tstate_t;

    logic [SYNC_STAGES-1:0] r_mem_sync_ff, r_tmds_sync_ff;
    logic                   w_mem_sync, w_tmds_sync;

    state_t            r_state, w_state_nx;
    logic [SW-1:0]     r_stable_cnt, w_stable_nx;
    logic [IW-1:0]     r_init_cnt, w_init_nx;
    logic [LW-1:0]     r_loss_cnt, w_loss_nx;
    logic [7:0]        r_loss_count, w_loss_count_nx;
    logic              r_mem_rst_n, r_sys_rst_n;

    tstate_t           r_tstate, w_tstate_nx;
    logic [SW-1:0]     r_thigh_cnt, w_thigh_nx;
    logic [LW-1:0]     r_tlow_cnt, w_tlow_nx;
    logic              r_tmds_rst_n;

    assign w_mem_sync  = r_mem_sync_ff[SYNC_STAGES-1];
    assign w_tmds_sync = r_tmds_sync_ff[SYNC_STAGES-1];

    // Synchronizer chains; the only place the raw ready levels are sampled.
    always_ff @(posedge CLK_BASE or negedge RESET_n) begin
        if (!RESET_n) begin
            r_mem_sync_ff  <= '0;
            r_tmds_sync_ff <= '0;
        end else begin
            r_mem_sync_ff  <= {r_mem_sync_ff[SYNC_STAGES-2:0], MEM_READY_IN};
            r_tmds_sync_ff <= {r_tmds_sync_ff[SYNC_STAGES-2:0], TMDS_READY_IN};
        end
    end

    // Main FSM next state: lock qualification, memory-init wait, loss filter.
    always_comb begin
        logic w_lost;
        w_state_nx      = r_state;
        w_stable_nx     = r_stable_cnt;
        w_init_nx       = r_init_cnt;
        w_loss_nx       = r_loss_cnt;
        w_loss_count_nx = r_loss_count;
        w_lost          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stable_nx = '0;
                w_init_nx   = '0;
                w_loss_nx   = '0;
                if (w_mem_sync) w_state_nx = ST_STABLE;
            end
            ST_STABLE: begin
                if (!w_mem_sync) begin
                    w_state_nx  = ST_IDLE;
                    w_stable_nx = '0;
                end else if (r_stable_cnt == STABLE_LAST) begin
                    w_state_nx = ST_MEM_INIT;
                    w_init_nx  = '0;
                    w_loss_nx  = '0;
                end else begin
                    w_stable_nx = r_stable_cnt + SW'(1);
                end
            end
            default: begin
                // MEM_INIT and RUN share loss detection; loss beats MEM_INIT->RUN.
                if (w_mem_sync)                   w_loss_nx = '0;
                else if (r_loss_cnt == LOSS_LAST) w_lost    = 1'b1;
                else                              w_loss_nx = r_loss_cnt + LW'(1);
                if (w_lost) begin
                    w_state_nx  = ST_IDLE;
                    w_loss_nx   = '0;
                    w_stable_nx = '0;
                    if (r_loss_count != 8'hFF) w_loss_count_nx = r_loss_count + 8'd1;
                end else if (r_state == ST_MEM_INIT) begin
                    if (r_init_cnt == INIT_LAST) w_state_nx = ST_RUN;
                    else                         w_init_nx  = r_init_cnt + IW'(1);
                end
            end
        endcase
    end

    // Main FSM registers; reset outputs are loaded from next state.
    always_ff @(posedge CLK_BASE or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state      <= ST_IDLE;
            r_stable_cnt <= '0;
            r_init_cnt   <= '0;
            r_loss_cnt   <= '0;
            r_loss_count <= '0;
            r_mem_rst_n  <= 1'b0;
            r_sys_rst_n  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_stable_cnt <= w_stable_nx;
            r_init_cnt   <= w_init_nx;
            r_loss_cnt   <= w_loss_nx;
            r_loss_count <= w_loss_count_nx;
            r_mem_rst_n  <= (w_state_nx == ST_MEM_INIT) || (w_state_nx == ST_RUN);
            r_sys_rst_n  <= (w_state_nx == ST_RUN);
        end
    end

    // TMDS FSM next state: independent lock qualify and loss filter.
    always_comb begin
        w_tstate_nx = r_tstate;
        w_thigh_nx  = r_thigh_cnt;
        w_tlow_nx   = r_tlow_cnt;
        if (r_tstate == T_HOLD) begin
            w_tlow_nx = '0;
            if (!w_tmds_sync) begin
                w_thigh_nx = '0;
            end else if (r_thigh_cnt == TMDS_LAST) begin
                w_tstate_nx = T_GO;
                w_thigh_nx  = '0;
            end else begin
                w_thigh_nx = r_thigh_cnt + SW'(1);
            end
        end else begin
            w_thigh_nx = '0;
            if (w_tmds_sync) begin
                w_tlow_nx = '0;
            end else if (r_tlow_cnt == LOSS_LAST) begin
                w_tstate_nx = T_HOLD;
                w_tlow_nx   = '0;
            end else begin
                w_tlow_nx = r_tlow_cnt + LW'(1);
            end
        end
    end

    // TMDS FSM registers and reset output.
    always_ff @(posedge CLK_BASE or negedge RESET_n) begin
        if (!RESET_n) begin
            r_tstate     <= T_HOLD;
            r_thigh_cnt  <= '0;
            r_tlow_cnt   <= '0;
            r_tmds_rst_n <= 1'b0;
        end else begin
            r_tstate     <= w_tstate_nx;
            r_thigh_cnt  <= w_thigh_nx;
            r_tlow_cnt   <= w_tlow_nx;
            r_tmds_rst_n <= (w_tstate_nx == T_GO);
        end
    end

    assign STATE        = r_state;
    assign MEM_RESET_n  = r_mem_rst_n;
    assign SYS_RESET_n  = r_sys_rst_n;
    assign TMDS_RESET_n = r_tmds_rst_n;
    assign LOSS_COUNT   = r_loss_count;

endmodule

// File: tb/tb_board_rev1_reset_seq.sv
// Self-checking bench for board_rev1_reset_seq: directed test-plan scenarios
// plus randomized ready traffic, compared every cycle to a run-length model.
module tb_board_rev1_reset_seq;

    localparam int S  = 2;
    localparam int L  = 8;
    localparam int MI = 16;
    localparam int LF = 4;

    logic       CLK_BASE = 1'b0;
    logic       RESET_n  = 1'b0;
    logic       MEM_READY_IN  = 1'b0;
    logic       TMDS_READY_IN = 1'b0;
    logic       MEM_RESET_n, SYS_RESET_n, TMDS_RESET_n;
    logic [1:0] STATE;
    logic [7:0] LOSS_COUNT;

    board_rev1_reset_seq #(
        .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L),
        .MEM_INIT_CYCLES(MI), .LOSS_FILTER(LF)
    ) dut (
        .CLK_BASE(CLK_BASE), .RESET_n(RESET_n),
        .MEM_READY_IN(MEM_READY_IN), .TMDS_READY_IN(TMDS_READY_IN),
        .MEM_RESET_n(MEM_RESET_n), .SYS_RESET_n(SYS_RESET_n),
        .TMDS_RESET_n(TMDS_RESET_n), .STATE(STATE), .LOSS_COUNT(LOSS_COUNT)
    );

    always #5 CLK_BASE = ~CLK_BASE;

    int n_chk = 0;
    int n_err = 0;

    // Model: ready history queues stand in for the synchronizers; lock is
    // judged from run lengths of synced highs/lows and time since mem release.
    logic mh[$];
    logic th[$];
    bit   m_rel;      // memory released (MEM_INIT or RUN)
    int   m_hrun;     // consecutive synced highs while not released
    int   m_lrun;     // consecutive synced lows while released
    int   m_age;      // edges since memory release
    int   m_loss;
    bit   t_go;
    int   t_hrun, t_lrun;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {19'd0, STATE, MEM_RESET_n, SYS_RESET_n, TMDS_RESET_n, LOSS_COUNT};
    endfunction

    function automatic logic [31:0] model_vec();
        logic [1:0] st;
        if (!m_rel) st = (m_hrun == 0) ? 2'd0 : 2'd1;
        else        st = (m_age >= MI) ? 2'd3 : 2'd2;
        return {19'd0, st, m_rel, (m_rel && m_age >= MI), t_go, 8'(m_loss)};
    endfunction

    task automatic model_reset();
        mh.delete(); th.delete();
        m_rel = 0; m_hrun = 0; m_lrun = 0; m_age = 0; m_loss = 0;
        t_go = 0; t_hrun = 0; t_lrun = 0;
    endtask

    task automatic model_edge(input logic m, input logic t);
        logic sm, st;
        sm = (mh.size() == S) ? mh[0] : 1'b0;
        st = (th.size() == S) ? th[0] : 1'b0;
        mh.push_back(m); if (mh.size() > S) void'(mh.pop_front());
        th.push_back(t); if (th.size() > S) void'(th.pop_front());
        if (!m_rel) begin
            m_hrun = sm ? m_hrun + 1 : 0;
            // first high enters STABLE, then L more highs release memory
            if (m_hrun >= L + 1) begin m_rel = 1; m_age = 0; m_lrun = 0; end
        end else begin
            m_lrun = sm ? 0 : m_lrun + 1;
            if (m_lrun == LF) begin
                m_rel = 0; m_hrun = 0;
                if (m_loss < 255) m_loss++;
            end else begin
                m_age++;
            end
        end
        if (!t_go) begin
            t_hrun = st ? t_hrun + 1 : 0;
            if (t_hrun == L + 1) begin t_go = 1; t_lrun = 0; end
        end else begin
            t_lrun = st ? 0 : t_lrun + 1;
            if (t_lrun == LF) begin t_go = 0; t_hrun = 0; end
        end
    endtask

    // Apply inputs (we sit 1 time unit after an edge), clock once, compare.
    task automatic step(input logic m, input logic t);
        MEM_READY_IN  = m;
        TMDS_READY_IN = t;
        @(posedge CLK_BASE);
        model_edge(m, t);
        #1;
        chk("cycle", dut_vec(), model_vec());
    endtask

    initial begin
        int up_st, up_mem, up_sys, up_tmds, down_mem;
        int ml, tl;
        logic mv, tv;

        // reset state
        model_reset();
        @(posedge CLK_BASE); #1;
        chk("reset_outputs", dut_vec(), 32'd0);
        @(posedge CLK_BASE); #1;
        RESET_n = 1'b1;

        // clean power-up
        up_st = -1; up_mem = -1; up_sys = -1;
        for (int k = 0; k < 31; k++) begin
            step(1'b1, 1'b0);
            if (STATE == 2'd1 && up_st < 0) up_st = k;
            if (MEM_RESET_n && up_mem < 0) up_mem = k;
            if (SYS_RESET_n && up_sys < 0) up_sys = k;
            if (SYS_RESET_n && !MEM_RESET_n) chk("order", 32'd1, 32'd0);
        end
        chk("pwr_stable_edge", up_st, 2);
        chk("pwr_mem_edge", up_mem, 10);
        chk("pwr_sys_edge", up_sys, 26);
        chk("pwr_loss", LOSS_COUNT, 0);

        // 3-cycle glitch in RUN is filtered
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
        chk("glitch3_state", STATE, 3);
        chk("glitch3_loss", LOSS_COUNT, 0);

        // 4-cycle low in RUN is a loss at edge 5
        down_mem = -1;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0);
            if (!MEM_RESET_n && down_mem < 0) begin
                down_mem = k;
                chk("loss_sys_with_mem", SYS_RESET_n, 0);
                chk("loss_state", STATE, 0);
                chk("loss_count1", LOSS_COUNT, 1);
            end
        end
        chk("loss_edge", down_mem, 5);

        // chatter during STABLE restarts qualification
        up_mem = -1;
        for (int k = 0; k < 30; k++) begin
            step(k != 5, 1'b0);
            if (k == 6) chk("chatter_pre", STATE, 1);
            if (k == 7) chk("chatter_idle", STATE, 0);
            if (MEM_RESET_n && up_mem < 0) up_mem = k;
        end
        chk("chatter_mem_edge", up_mem, 16);

        // loss coinciding with terminal init count
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        up_sys = -1;
        for (int k = 0; k < 46; k++) begin
            step(k < 21, 1'b0);
            if (k == 25) chk("coinc_pre", STATE, 2);
            if (k == 26) chk("coinc_state", STATE, 0);
            if (SYS_RESET_n && up_sys < 0) up_sys = k;
        end
        chk("coinc_no_sys", up_sys, -1);

        // TMDS independence
        up_tmds = -1;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b1);
            if (TMDS_RESET_n && up_tmds < 0) up_tmds = k;
            if (STATE != 2'd0) chk("tmds_state_idle", STATE, 0);
        end
        chk("tmds_edge", up_tmds, 10);
        for (int k = 0; k < 40; k++) step(1'b1, 1'($urandom_range(0, 1)));
        chk("tmds_toggle_state", STATE, 3);
        chk("tmds_toggle_loss", LOSS_COUNT, 32'(m_loss));

        // randomized run-length traffic on both inputs
        mv = 1'b1; tv = 1'b1; ml = 0; tl = 0;
        for (int k = 0; k < 3000; k++) begin
            if (ml == 0) begin mv = ~mv; ml = $urandom_range(1, 40); end
            if (tl == 0) begin tv = ~tv; tl = $urandom_range(1, 20); end
            ml--; tl--;
            step(mv, tv);
            if (SYS_RESET_n && !MEM_RESET_n) chk("rand_order", 32'd1, 32'd0);
        end

        // loss counter saturation
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
            for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
        end
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
        chk("loss_saturated", LOSS_COUNT, 255);

        // async reset mid MEM_INIT
        for (int k = 0; k < 15; k++) step(1'b1, 1'b0);
        chk("pre_areset_state", STATE, 2);
        RESET_n = 1'b0;
        #1;
        chk("areset_immediate", dut_vec(), 32'd0);
        @(posedge CLK_BASE); @(posedge CLK_BASE); #1;
        chk("areset_held", dut_vec(), 32'd0);
        RESET_n = 1'b1;
        model_reset();
        up_mem = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0);
            if (MEM_RESET_n && up_mem < 0) up_mem = k;
        end
        chk("areset_mem_edge", up_mem, 10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
